// File: rtl/dut.sv
// Register-mapped 1-bit OR accelerator: two input FIFOs feed Y = A | B into an
// output FIFO, with status/data registers on separate write and read ports.

module dut_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic          mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // Full/empty come from start-of-cycle occupancy, so a full FIFO rejects a
  // push even while it is being popped in the same cycle.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == LAST_PTR) ? '0 : wptr + PW'(1);
      if (do_pop)  rptr <= (rptr == LAST_PTR) ? '0 : rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

module dut #(
  parameter int A_DEPTH = 2,
  parameter int B_DEPTH = 2,
  parameter int Y_DEPTH = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] write_address,
  input  logic       write_data,
  input  logic       write_en,
  output logic       write_rdy,
  input  logic [2:0] read_address,
  input  logic       read_en,
  output logic       read_data,
  output logic       read_rdy
);

  logic a_head, a_full, a_empty;
  logic b_head, b_full, b_empty;
  logic y_head, y_full, y_empty;
  logic fire;

  // No bypass into Y: the rule needs room in Y at the start of the cycle, so a
  // same-cycle Y pop does not make room until the following edge.
  assign fire = !a_empty && !b_empty && !y_full;

  dut_fifo #(.DEPTH(A_DEPTH)) u_fifo_a (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (write_en && (write_address == 3'd4)),
    .pop   (fire),
    .din   (write_data),
    .head  (a_head),
    .full  (a_full),
    .empty (a_empty)
  );

  dut_fifo #(.DEPTH(B_DEPTH)) u_fifo_b (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (write_en && (write_address == 3'd5)),
    .pop   (fire),
    .din   (write_data),
    .head  (b_head),
    .full  (b_full),
    .empty (b_empty)
  );

  dut_fifo #(.DEPTH(Y_DEPTH)) u_fifo_y (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (fire),
    .pop   (read_en && (read_address == 3'd3)),
    .din   (a_head | b_head),
    .head  (y_head),
    .full  (y_full),
    .empty (y_empty)
  );

  assign write_rdy = 1'b1;
  assign read_rdy  = 1'b1;

  always_comb begin
    read_data = 1'b0;
    case (read_address)
      3'd0:    read_data = !a_full;
      3'd1:    read_data = !b_full;
      3'd2:    read_data = !y_empty;
      3'd3:    read_data = y_empty ? 1'b0 : y_head;
      default: read_data = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dut.sv
// Bench for the OR accelerator: queue-based reference model checked every
// cycle, plus directed register sequences with literal expectations.

module tb_dut;

  localparam int A_DEPTH = 2;
  localparam int B_DEPTH = 2;
  localparam int Y_DEPTH = 1;

  logic       CLK;
  logic       RST_N;
  logic [2:0] write_address;
  logic       write_data;
  logic       write_en;
  logic       write_rdy;
  logic [2:0] read_address;
  logic       read_en;
  logic       read_data;
  logic       read_rdy;

  int checks = 0;
  int errors = 0;
  bit model_valid = 0;

  bit qa[$];
  bit qb[$];
  bit qy[$];

  dut #(.A_DEPTH(A_DEPTH), .B_DEPTH(B_DEPTH), .Y_DEPTH(Y_DEPTH)) u_dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .write_address (write_address),
    .write_data    (write_data),
    .write_en      (write_en),
    .write_rdy     (write_rdy),
    .read_address  (read_address),
    .read_en       (read_en),
    .read_data     (read_data),
    .read_rdy      (read_rdy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit modelRead(input logic [2:0] addr);
    case (addr)
      3'd0:    return qa.size() < A_DEPTH;
      3'd1:    return qb.size() < B_DEPTH;
      3'd2:    return qy.size() > 0;
      3'd3:    return (qy.size() > 0) ? qy[0] : 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: every decision uses the occupancy seen at the edge.
  always @(posedge CLK) begin
    int  a_sz, b_sz, y_sz;
    bit  fire, wa, wb, yd, v;
    if (!RST_N) begin
      qa.delete();
      qb.delete();
      qy.delete();
      model_valid = 1;
    end else begin
      a_sz = qa.size();
      b_sz = qb.size();
      y_sz = qy.size();
      fire = (a_sz > 0) && (b_sz > 0) && (y_sz < Y_DEPTH);
      wa   = write_en && (write_address == 3'd4) && (a_sz < A_DEPTH);
      wb   = write_en && (write_address == 3'd5) && (b_sz < B_DEPTH);
      yd   = read_en && (read_address == 3'd3) && (y_sz > 0);
      v    = 0;
      if (yd) void'(qy.pop_front());
      if (fire) v = qa.pop_front() | qb.pop_front();
      if (wa) qa.push_back(write_data);
      if (wb) qb.push_back(write_data);
      if (fire) qy.push_back(v);
    end
  end

  always @(negedge CLK) begin
    if (model_valid) begin
      checkOutput("model_read_data", read_data, modelRead(read_address));
      checkOutput("write_rdy", write_rdy, 1'b1);
      checkOutput("read_rdy", read_rdy, 1'b1);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] waddr, input logic wdata, input logic wen,
                               input logic [2:0] raddr, input logic ren);
    write_address = waddr;
    write_data    = wdata;
    write_en      = wen;
    read_address  = raddr;
    read_en       = ren;
  endtask

  task automatic wr(input logic [2:0] addr, input logic data);
    applyStimulus(addr, data, 1'b1, 3'd7, 1'b0);
    tick();
    applyStimulus(3'd0, 1'b0, 1'b0, 3'd7, 1'b0);
  endtask

  task automatic peek(input logic [2:0] addr, input logic exp, input string name);
    applyStimulus(3'd0, 1'b0, 1'b0, addr, 1'b0);
    @(negedge CLK);
    checkOutput(name, read_data, exp);
    tick();
  endtask

  task automatic pop(input logic exp, input string name);
    applyStimulus(3'd0, 1'b0, 1'b0, 3'd3, 1'b1);
    @(negedge CLK);
    checkOutput(name, read_data, exp);
    tick();
    applyStimulus(3'd0, 1'b0, 1'b0, 3'd7, 1'b0);
  endtask

  task automatic doReset();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
  endtask

  initial begin
    logic [1:0] ab;
    RST_N = 1'b0;
    applyStimulus(3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();

    peek(3'd0, 1'b1, "reset_a_status");
    peek(3'd1, 1'b1, "reset_b_status");
    peek(3'd2, 1'b0, "reset_y_status");
    peek(3'd3, 1'b0, "reset_y_output");
    RST_N = 1'b1;

    wr(3'd4, 1'b1);
    wr(3'd5, 1'b0);
    tick();
    tick();
    peek(3'd2, 1'b1, "first_y_status");
    pop(1'b1, "first_y_value");
    peek(3'd2, 1'b0, "first_y_drained");

    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      wr(3'd4, ab[1]);
      wr(3'd5, ab[0]);
      tick();
      tick();
      peek(3'd2, 1'b1, $sformatf("truth_status_%0d", i));
      pop(ab[1] | ab[0], $sformatf("truth_value_%0d", i));
    end

    doReset();
    wr(3'd4, 1'b1);
    wr(3'd4, 1'b0);
    peek(3'd0, 1'b0, "a_full_status");
    wr(3'd4, 1'b1);
    wr(3'd4, 1'b1);
    wr(3'd5, 1'b0);
    wr(3'd5, 1'b0);
    tick();
    pop(1'b1, "overflow_first");
    tick();
    pop(1'b0, "overflow_second");
    peek(3'd0, 1'b1, "a_drained_status");
    wr(3'd5, 1'b1);
    tick();
    tick();
    peek(3'd2, 1'b0, "dropped_writes_gone");

    doReset();
    wr(3'd4, 1'b1);
    wr(3'd5, 1'b0);
    wr(3'd4, 1'b0);
    wr(3'd5, 1'b0);
    tick();
    tick();
    peek(3'd0, 1'b1, "backpressure_a_status");
    peek(3'd2, 1'b1, "backpressure_y_status");
    pop(1'b1, "order_first");
    tick();
    pop(1'b0, "order_second");
    peek(3'd2, 1'b0, "order_drained");

    wr(3'd4, 1'b1);
    wr(3'd5, 1'b1);
    tick();
    tick();
    wr(3'd4, 1'b0);
    wr(3'd5, 1'b1);
    peek(3'd2, 1'b1, "pre_reset_y_status");
    doReset();
    peek(3'd0, 1'b1, "midreset_a_status");
    peek(3'd1, 1'b1, "midreset_b_status");
    peek(3'd2, 1'b0, "midreset_y_status");
    pop(1'b0, "midreset_y_output");
    wr(3'd0, 1'b1);
    wr(3'd6, 1'b1);
    peek(3'd0, 1'b1, "ignored_write_a_status");
    peek(3'd1, 1'b1, "ignored_write_b_status");
    peek(3'd2, 1'b0, "ignored_write_y_status");
    wr(3'd5, 1'b1);
    tick();
    tick();
    peek(3'd2, 1'b0, "midreset_a_discarded");

    for (int i = 0; i < 4000; i++) begin
      write_en      = 1'($urandom_range(0, 1));
      write_address = ($urandom_range(0, 3) != 0) ? 3'(4 + $urandom_range(0, 1))
                                                  : 3'($urandom_range(0, 7));
      write_data    = 1'($urandom_range(0, 1));
      read_en       = 1'($urandom_range(0, 2) == 0);
      read_address  = ($urandom_range(0, 1) != 0) ? 3'd3 : 3'($urandom_range(0, 7));
      RST_N         = ($urandom_range(0, 299) != 0);
      tick();
    end
    RST_N = 1'b1;
    applyStimulus(3'd0, 1'b0, 1'b0, 3'd7, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dut.md
Name: dut

Overview:
- Register-mapped 1-bit OR accelerator.
- Two input FIFOs (A, B) are loaded through a write port. An internal rule computes Y = A | B into an output FIFO, which is drained through a read port.
- Status registers expose FIFO occupancy for software-style polling by a testbench or bus master.

Parameters:
- A_DEPTH, 2, entries in input FIFO A
- B_DEPTH, 2, entries in input FIFO B
- Y_DEPTH, 1, entries in output FIFO Y

Ports:
- CLK  input  1  clock, rising-edge active
- RST_N  input  1  reset, synchronous, active-low
- write_address  input  3  target register of a write
- write_data  input  1  data bit to write
- write_en  input  1  write strobe, sampled at rising CLK
- write_rdy  output  1  write port ready
- read_address  input  3  register to read
- read_en  input  1  read strobe; side effects at rising CLK
- read_data  output  1  read value
- read_rdy  output  1  read port ready

Behaviour:
- One clock (CLK); reset is synchronous and active-low (RST_N sampled at rising CLK).
- Reset clears all FIFOs to empty. write_rdy and read_rdy are 1 in every cycle, including during reset. read_data reflects the empty state.
- Address map, read side:
  - 0 A_STATUS: 1 if A not full.
  - 1 B_STATUS: 1 if B not full.
  - 2 Y_STATUS: 1 if Y not empty.
  - 3 Y_OUTPUT: head of Y, or 0 if Y empty.
  - 4–7: read as 0.
- Address map, write side:
  - 4 A_DATA: enqueue write_data into A.
  - 5 B_DATA: enqueue write_data into B.
  - 0–3, 6, 7: writes ignored.
- Writes:
  - On a rising edge with write_en=1 and address 4 or 5, the bit is enqueued if that FIFO is not full. A write to a full FIFO is silently dropped.
- Reads:
  - read_data is combinational from read_address and current state; it does not depend on read_en.
  - A rising edge with read_en=1 and read_address=3 dequeues Y if Y is non-empty. A read of an empty Y returns 0 and has no effect.
  - Status reads have no side effects.
- OR rule, evaluated every rising edge outside reset:
  - Fires if A non-empty, B non-empty, and Y empty at the start of the cycle.
  - Action: dequeue A and B; enqueue (A.head | B.head) into Y.
  - Y has no bypass: data written at edge N reaches Y no earlier than edge N+1. Y_STATUS reads 1 after that edge.
  - If Y is full, A and B hold their data; the rule retries each cycle.
  - A Y dequeue and an OR-rule enqueue in the same cycle: the enqueue is blocked that cycle (Y was full at the start), so Y refills one cycle later.
- Simultaneous A/B write and OR-rule dequeue in the same cycle: both take effect. FIFO full/empty is evaluated on start-of-cycle occupancy, so a full FIFO still rejects a write even if it is being dequeued.
- A and B each preserve FIFO order. Occupancy counters saturate correctly at 0 and DEPTH; pointers wrap modulo depth.
- Reset asserted mid-operation discards all queued data at that edge.

Test Plan:
- After reset, read addresses 0,1,2,3 -> 1,1,0,0; write_rdy=read_rdy=1.
- Write A=1 then B=0; wait 2 cycles; read addr 2 -> 1; read addr 3 with read_en -> 1. Then addr 2 -> 0.
- Loop over all four (a,b) combinations: read addr 3 -> 0,1,1,1 respectively (OR truth table). Poll addr 2 before each read.
- Write A four times with no B: after 2 writes addr 0 -> 0; the 3rd and 4th writes are dropped. Then write B=0 twice and drain Y twice: values equal the first two A bits. Then addr 0 -> 1.
- Fill A and B with 2 pairs, do not read Y: Y holds the first result and A/B keep one entry each. Read Y, wait 1 cycle, read again -> both results in order.
- Queue data in A, B and Y, then assert RST_N=0 for 1 cycle -> statuses return 1,1,0; addr 3 -> 0. Writes to addr 0 and 6 do not alter any status.
